// File: rtl/ins_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// ins_prefetch_buffer
//
// Instruction prefetch buffer sitting between a processor fetch stage and an
// instruction memory with a request/grant + in-order read-valid protocol.
// Requests are issued ahead of the processor as long as buffered plus
// in-flight words stay below DEPTH. A redirect throws away all buffered
// words, restarts fetching at the new address and silently swallows the
// responses that were still in flight (FLUSH state).
//
// Ports
//   cpu_clock      : sole clock, rising edge
//   cpu_reset_b    : synchronous reset, ACTIVE HIGH despite the _b suffix
//   mem_req/addr   : fetch request and word-aligned address (held until grant)
//   mem_gnt        : memory accepts the current request
//   mem_rvalid/rdata : in-order read response
//   ins_fetch_req  : processor consumes the head instruction
//   ins_valid      : head entry holds an instruction
//   instruction/ins_pc : registered head entry (word and its address)
//   redirect/redirect_pc : discard everything and restart at redirect_pc
//   fetch_err      : sticky, a response arrived with nothing outstanding
// -----------------------------------------------------------------------------
module ins_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        cpu_clock,
    input  logic        cpu_reset_b,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        ins_fetch_req,
    output logic        ins_valid,
    output logic [31:0] instruction,
    output logic [31:0] ins_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_err
);

    localparam int PTR_W = $clog2(DEPTH);
    // Counters must represent 0..DEPTH inclusive.
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C      = CNT_W'(DEPTH);
    localparam logic [31:0]      RESET_PC_ALN = RESET_PC & 32'hFFFF_FFFC;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   discard_q, discard_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic               fetch_err_q, fetch_err_d;

    logic               grant;
    logic               out_dec;
    logic               disc_dec;
    logic               spurious;
    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   inflight;
    logic [31:0]        target_pc;

    logic [31:0]        pc_ent   [DEPTH];
    logic [31:0]        data_ent [DEPTH];

    // -------------------------------------------------------------------------
    // Event decode
    // -------------------------------------------------------------------------
    always_comb begin : event_decode
        grant     = mem_req && mem_gnt;
        // A response retires a live request first; only when none is live does
        // it count against the discard budget left behind by a redirect.
        out_dec   = mem_rvalid && (outstanding_q != '0);
        disc_dec  = mem_rvalid && (outstanding_q == '0) && (discard_q != '0);
        spurious  = mem_rvalid && (outstanding_q == '0) && (discard_q == '0);
        push      = out_dec && (state_q == ST_RUN) && !redirect;
        pop       = ins_valid && ins_fetch_req && !redirect;
        target_pc = redirect_pc & 32'hFFFF_FFFC;
        // Work still owed by memory after this edge. Outstanding and discard
        // are never both non-zero, so the sum stays within 0..DEPTH.
        inflight  = outstanding_q + discard_q + CNT_W'(grant)
                    - CNT_W'(out_dec || disc_dec);
    end

    // -------------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge cpu_clock) begin : state_reg
        if (cpu_reset_b) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        if (redirect) begin
            state_d = (inflight != '0) ? ST_FLUSH : ST_RUN;
        end else if ((state_q == ST_FLUSH) && (discard_q == '0)) begin
            state_d = ST_RUN;
        end
    end

    always_comb begin : fsm_outputs
        // Request purely from registered state. Gating with the reset input
        // keeps mem_req low for the whole reset window, not just before the
        // first reset edge.
        mem_req     = !cpu_reset_b && (state_q == ST_RUN)
                      && ((count_q + outstanding_q) < DEPTH_C);
        mem_addr    = fetch_pc_q;
        ins_valid   = (count_q != '0);
        instruction = data_ent[rd_ptr_q];
        ins_pc      = pc_ent[rd_ptr_q];
        fetch_err   = fetch_err_q;
    end

    // -------------------------------------------------------------------------
    // Datapath next state
    // -------------------------------------------------------------------------
    always_comb begin : datapath_next
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        fetch_err_d   = fetch_err_q | spurious;

        if (redirect) begin
            // Everything owed by memory becomes discard budget; the response
            // pc restarts together with the fetch pc.
            fetch_pc_d    = target_pc;
            resp_pc_d     = target_pc;
            outstanding_d = '0;
            discard_d     = inflight;
            count_d       = '0;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (push) begin
                resp_pc_d = resp_pc_q + 32'd4;
                wr_ptr_d  = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(out_dec);
            discard_d     = discard_q - CNT_W'(disc_dec);
            count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge cpu_clock) begin : datapath_reg
        if (cpu_reset_b) begin
            fetch_pc_q    <= RESET_PC_ALN;
            resp_pc_q     <= RESET_PC_ALN;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            fetch_err_q   <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Buffer entries. Each slot is cleared on reset so the head reads as zero
    // until the first instruction lands.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [31:0] pc_q, pc_d;
            logic [31:0] data_q, data_d;

            always_comb begin
                pc_d   = pc_q;
                data_d = data_q;
                if (push && (wr_ptr_q == PTR_W'(gi))) begin
                    pc_d   = resp_pc_q;
                    data_d = mem_rdata;
                end
            end

            always_ff @(posedge cpu_clock) begin
                if (cpu_reset_b) begin
                    pc_q   <= '0;
                    data_q <= '0;
                end else begin
                    pc_q   <= pc_d;
                    data_q <= data_d;
                end
            end

            assign pc_ent[gi]   = pc_q;
            assign data_ent[gi] = data_q;
        end
    endgenerate

endmodule

// File: tb/tb_ins_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_ins_prefetch_buffer
//
// Directed bench for ins_prefetch_buffer. A bench-side memory model records
// every grant, answers one cycle later when enabled, and pushes the expected
// {pc, word} into a scoreboard queue when a response should be buffered. The
// head entry, ins_valid, mem_req/mem_addr and fetch_err are compared every
// cycle against that model. A second instance with RESET_PC near the top of
// the address space exercises address wrap.
// -----------------------------------------------------------------------------
module tb_ins_prefetch_buffer;

    localparam int DEPTH = 4;

    logic        cpu_clock = 1'b0;
    logic        cpu_reset_b;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        ins_fetch_req;
    logic        ins_valid;
    logic [31:0] instruction;
    logic [31:0] ins_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_err;

    // Wrap-test instance: always granted, never answered, never popped.
    logic        w_mem_req;
    logic [31:0] w_mem_addr;
    logic        w_mem_gnt;
    logic        w_mem_rvalid;
    logic [31:0] w_mem_rdata;
    logic        w_ins_fetch_req;
    logic        w_ins_valid;
    logic [31:0] w_instruction;
    logic [31:0] w_ins_pc;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic        w_fetch_err;

    always #5 cpu_clock = ~cpu_clock;

    ins_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .cpu_clock     (cpu_clock),
        .cpu_reset_b   (cpu_reset_b),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .ins_fetch_req (ins_fetch_req),
        .ins_valid     (ins_valid),
        .instruction   (instruction),
        .ins_pc        (ins_pc),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .fetch_err     (fetch_err)
    );

    ins_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .cpu_clock     (cpu_clock),
        .cpu_reset_b   (cpu_reset_b),
        .mem_req       (w_mem_req),
        .mem_addr      (w_mem_addr),
        .mem_gnt       (w_mem_gnt),
        .mem_rvalid    (w_mem_rvalid),
        .mem_rdata     (w_mem_rdata),
        .ins_fetch_req (w_ins_fetch_req),
        .ins_valid     (w_ins_valid),
        .instruction   (w_instruction),
        .ins_pc        (w_ins_pc),
        .redirect      (w_redirect),
        .redirect_pc   (w_redirect_pc),
        .fetch_err     (w_fetch_err)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    ent_t        exp_q[$];   // expected buffer contents, head first
    logic [31:0] pend[$];    // granted, not yet answered (addresses)

    int          passed = 0;
    int          total  = 0;
    int          failed = 0;

    int          m_disc;
    bit          m_flush;
    bit          m_err;
    logic [31:0] exp_addr;

    bit          gnt_en, rsp_en, pop_en, redir_pend, spur_pend;
    logic [31:0] redir_target;

    int          n_grants, n_pops, w_cyc;
    logic [31:0] last_gnt_addr, first_pop_pc;
    bit          first_pop_seen;
    logic [31:0] wrap_exp [4];

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1234_5678;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive inputs just after the rising edge, check and
    // advance the model on the falling edge, then return just after the
    // next rising edge.
    task automatic cyc();
        bit          red, gr, exp_req;
        int          old_disc;
        logic [31:0] a;

        mem_gnt       = gnt_en;
        ins_fetch_req = pop_en;
        redirect      = redir_pend;
        redirect_pc   = redir_target;
        redir_pend    = 1'b0;
        if (spur_pend) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEAD_BEEF;
            spur_pend  = 1'b0;
        end else if (rsp_en && pend.size() > 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = memword(pend[0]);
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end

        @(negedge cpu_clock);
        if (!cpu_reset_b) begin
            exp_req = !m_flush && ((exp_q.size() + pend.size()) < DEPTH);
            check("ins_valid", 32'(ins_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("ins_pc", ins_pc, exp_q[0].pc);
                check("instruction", instruction, exp_q[0].data);
            end
            check("mem_req", 32'(mem_req), 32'(exp_req));
            if (exp_req) check("mem_addr", mem_addr, exp_addr);
            check("fetch_err", 32'(fetch_err), 32'(m_err));

            if (w_cyc < 4) begin
                check("wrap_req", 32'(w_mem_req), 32'd1);
                check("wrap_addr", w_mem_addr, wrap_exp[w_cyc]);
            end else if (w_cyc == 4) begin
                check("wrap_req_stop", 32'(w_mem_req), 32'd0);
                check("wrap_valid", 32'(w_ins_valid), 32'd0);
            end
            w_cyc++;

            // Observed-activity counters for the directed checks.
            if (mem_req && mem_gnt) begin
                n_grants++;
                last_gnt_addr = mem_addr;
            end
            if (ins_valid && ins_fetch_req && !redirect) begin
                n_pops++;
                if (!first_pop_seen) begin
                    first_pop_seen = 1'b1;
                    first_pop_pc   = ins_pc;
                end
            end

            // Model update for the coming edge.
            red      = redirect;
            gr       = exp_req && mem_gnt;
            old_disc = m_disc;
            if (ins_fetch_req && !red && exp_q.size() != 0) void'(exp_q.pop_front());
            if (mem_rvalid) begin
                if (pend.size() == 0) begin
                    m_err = 1'b1;
                end else begin
                    a = pend.pop_front();
                    if (m_disc > 0) m_disc--;
                    else if (!red) exp_q.push_back('{pc: a, data: memword(a)});
                end
            end
            if (gr) begin
                pend.push_back(exp_addr);
                exp_addr = exp_addr + 32'd4;
            end
            if (red) begin
                exp_q.delete();
                m_disc   = pend.size();
                m_flush  = (m_disc > 0);
                exp_addr = redir_target & 32'hFFFF_FFFC;
            end else if (m_flush && old_disc == 0) begin
                m_flush = 1'b0;
            end
        end
        @(posedge cpu_clock);
        #1;
    endtask

    task automatic do_reset();
        cpu_reset_b = 1'b1;
        exp_q.delete();
        pend.delete();
        m_disc = 0; m_flush = 1'b0; m_err = 1'b0; exp_addr = 32'h0;
        gnt_en = 1'b0; rsp_en = 1'b0; pop_en = 1'b0;
        redir_pend = 1'b0; spur_pend = 1'b0;
        repeat (2) cyc();
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_ins_valid", 32'(ins_valid), 32'd0);
        check("rst_instruction", instruction, 32'h0);
        check("rst_ins_pc", ins_pc, 32'h0);
        check("rst_fetch_err", 32'(fetch_err), 32'd0);
        check("rst_wrap_addr", w_mem_addr, 32'hFFFF_FFF8);
        cpu_reset_b = 1'b0;
        w_cyc = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        wrap_exp        = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        cpu_reset_b     = 1'b1;
        mem_gnt         = 1'b0;
        mem_rvalid      = 1'b0;
        mem_rdata       = '0;
        ins_fetch_req   = 1'b0;
        redirect        = 1'b0;
        redirect_pc     = '0;
        redir_target    = '0;
        w_mem_gnt       = 1'b1;
        w_mem_rvalid    = 1'b0;
        w_mem_rdata     = '0;
        w_ins_fetch_req = 1'b0;
        w_redirect      = 1'b0;
        w_redirect_pc   = '0;
        w_cyc           = 0;
        n_grants        = 0;
        n_pops          = 0;
        first_pop_seen  = 1'b0;
        first_pop_pc    = '0;
        last_gnt_addr   = '0;

        do_reset();

        // Backpressure: no pops -> buffer fills with exactly DEPTH grants.
        gnt_en = 1'b1; rsp_en = 1'b1; pop_en = 1'b0; n_grants = 0;
        repeat (8) cyc();
        check("bp_grants", n_grants, 32'd4);
        check("bp_mem_req", 32'(mem_req), 32'd0);
        check("bp_valid", 32'(ins_valid), 32'd1);
        check("bp_head_pc", ins_pc, 32'h0);

        // One pop frees one slot -> exactly one more request, at 0x10.
        pop_en = 1'b1;
        cyc();
        pop_en = 1'b0; n_grants = 0;
        repeat (5) cyc();
        check("bp_one_grant", n_grants, 32'd1);
        check("bp_refill_addr", last_gnt_addr, 32'h10);

        // Streaming from a full buffer: one instruction every cycle.
        pop_en = 1'b1; n_pops = 0;
        repeat (20) cyc();
        check("stream_pops", n_pops, 32'd20);

        // Drain.
        gnt_en = 1'b0;
        repeat (8) cyc();
        check("drain_empty", 32'(ins_valid), 32'd0);

        // Redirect with two requests outstanding.
        pop_en = 1'b0; rsp_en = 1'b0; gnt_en = 1'b1;
        repeat (2) cyc();
        gnt_en = 1'b0; redir_target = 32'h0000_0103; redir_pend = 1'b1;
        cyc();
        repeat (3) cyc();
        check("flush_req_low", 32'(mem_req), 32'd0);
        rsp_en = 1'b1; gnt_en = 1'b1; pop_en = 1'b1; first_pop_seen = 1'b0;
        repeat (10) cyc();
        check("redir_first_pc", first_pop_pc, 32'h100);

        // Redirect in the middle of streaming (coincident grant and rvalid).
        repeat (3) cyc();
        redir_target = 32'h0000_0200; redir_pend = 1'b1;
        repeat (12) cyc();

        // Redirect with nothing in flight stays in RUN.
        gnt_en = 1'b0;
        repeat (6) cyc();
        redir_target = 32'h0000_0302; redir_pend = 1'b1;
        cyc();
        check("quiet_redir_req", 32'(mem_req), 32'd1);
        check("quiet_redir_addr", mem_addr, 32'h300);
        gnt_en = 1'b1;
        repeat (6) cyc();

        // Spurious response with nothing outstanding.
        pop_en = 1'b0; gnt_en = 1'b1; rsp_en = 1'b1;
        repeat (10) cyc();
        gnt_en = 1'b0;
        repeat (2) cyc();
        spur_pend = 1'b1;
        cyc();
        check("spur_err", 32'(fetch_err), 32'd1);
        check("spur_valid", 32'(ins_valid), 32'd1);
        pop_en = 1'b1;
        repeat (2) cyc();
        pop_en = 1'b0;
        cyc();

        // Reset pulse clears the sticky error and the buffer.
        do_reset();
        gnt_en = 1'b1; rsp_en = 1'b1; pop_en = 1'b1;
        repeat (12) cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
